// File: rtl/branch_cmp_scheduler_if.sv
// Request/response channels of the shared branch-comparator scheduler.
// Requester side is the master; the scheduler is the slave.
interface branch_cmp_scheduler_if #(
    parameter int DWIDTH = 32,
    parameter int NREQ   = 2,
    parameter int IDW    = 1
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*DWIDTH-1:0] req_a;
    logic [NREQ*DWIDTH-1:0] req_b;
    logic [NREQ*3-1:0]      req_funct3;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [IDW-1:0]         rsp_id;
    logic                   rsp_taken;
    logic                   rsp_eq;
    logic                   rsp_lt;
    logic                   rsp_err;

    modport master (
        output req_valid, req_a, req_b, req_funct3, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_taken, rsp_eq, rsp_lt, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_funct3, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_taken, rsp_eq, rsp_lt, rsp_err
    );
endinterface

// File: rtl/branch_cmp_scheduler.sv
// Round-robin sharing of one external branch comparator between NREQ requesters;
// decodes RV32I branch funct3 into a taken flag on a single tagged response channel.
module branch_cmp_scheduler #(
    parameter int DWIDTH = 32,
    parameter int NREQ   = 2,
    parameter int IDW    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    branch_cmp_scheduler_if.slave bus,
    output logic [DWIDTH-1:0]     cmp_a,
    output logic [DWIDTH-1:0]     cmp_b,
    output logic                  cmp_br_un,
    input  logic                  cmp_br_eq,
    input  logic                  cmp_br_lt
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

    state_t          state;
    logic [PW-1:0]   rr_ptr;
    logic [2:0]      funct3_q;
    logic            rsp_valid_q;
    logic [IDW-1:0]  rsp_id_q;
    logic            rsp_taken_q;
    logic            rsp_eq_q;
    logic            rsp_lt_q;
    logic            rsp_err_q;

    logic            gnt_found;
    logic [PW-1:0]   gnt_idx;
    logic            taken_d;
    logic            err_d;

    logic [DWIDTH-1:0] a_arr  [NREQ];
    logic [DWIDTH-1:0] b_arr  [NREQ];
    logic [2:0]        f3_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign a_arr[i]  = bus.req_a[i*DWIDTH +: DWIDTH];
        assign b_arr[i]  = bus.req_b[i*DWIDTH +: DWIDTH];
        assign f3_arr[i] = bus.req_funct3[i*3 +: 3];
    end

    // Wrap is a compare-and-subtract so non-power-of-2 NREQ works.
    function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return PW'(s);
    endfunction

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_found && bus.req_valid[rr_idx(rr_ptr, k)]) begin
                gnt_found = 1'b1;
                gnt_idx   = rr_idx(rr_ptr, k);
            end
        end
    end

    // Ready is combinational; held off during reset so nothing handshakes then.
    always_comb begin
        bus.req_ready = '0;
        if (rst_n && state == IDLE && gnt_found) bus.req_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        taken_d = 1'b0;
        err_d   = 1'b0;
        case (funct3_q)
            3'b000:         taken_d = cmp_br_eq;
            3'b001:         taken_d = !cmp_br_eq;
            3'b100, 3'b110: taken_d = cmp_br_lt;
            3'b101, 3'b111: taken_d = !cmp_br_lt;
            default:        err_d   = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            cmp_a       <= '0;
            cmp_b       <= '0;
            cmp_br_un   <= 1'b0;
            funct3_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_taken_q <= 1'b0;
            rsp_eq_q    <= 1'b0;
            rsp_lt_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        cmp_a     <= a_arr[gnt_idx];
                        cmp_b     <= b_arr[gnt_idx];
                        cmp_br_un <= f3_arr[gnt_idx][1];
                        funct3_q  <= f3_arr[gnt_idx];
                        rsp_id_q  <= IDW'(gnt_idx);
                        rr_ptr    <= rr_idx(gnt_idx, 1);
                        state     <= CMP;
                    end
                end
                CMP: begin
                    rsp_eq_q    <= cmp_br_eq;
                    rsp_lt_q    <= cmp_br_lt;
                    rsp_taken_q <= taken_d;
                    rsp_err_q   <= err_d;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_taken = rsp_taken_q;
    assign bus.rsp_eq    = rsp_eq_q;
    assign bus.rsp_lt    = rsp_lt_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule
